// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC register, fetch register (ir/ir_pc/ir_valid) and RUN/HALT control.
// Define IFETCH_HALT_DETECT_EN to stop fetching on opcode 4'b1111; otherwise HALT is unreachable.
module ifetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [7:0]  redirect_addr,
    input  logic [15:0] instr_in,
    output logic [7:0]  pc_out,
    output logic [15:0] ir,
    output logic [7:0]  ir_pc,
    output logic        ir_valid,
    output logic        halted
);

    typedef enum logic {RUN, HALT} state_t;

    state_t     state;
    logic [7:0] pc;

    assign pc_out = pc;

    // Redirect wins over stall and over HALT; ir/ir_pc are left as-is behind the bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            ir       <= 16'h0000;
            ir_pc    <= 8'h00;
            ir_valid <= 1'b0;
            state    <= RUN;
        end else if (redirect) begin
            pc       <= redirect_addr;
            ir_valid <= 1'b0;
            state    <= RUN;
        end else if (state == RUN) begin
            if (!stall) begin
                ir       <= instr_in;
                ir_pc    <= pc;
                ir_valid <= 1'b1;
`ifdef IFETCH_HALT_DETECT_EN
                if (instr_in[15:12] == 4'b1111)
                    state <= HALT;
                else
                    pc <= pc + 8'd1;
`else
                pc <= pc + 8'd1;
`endif
            end
        end else begin
            if (!stall)
                ir_valid <= 1'b0;
        end
    end

`ifdef IFETCH_HALT_DETECT_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, giving the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port stall, input, 1 bit: decode not ready; holds the fetch stage.
REQ-005 SHALL have port redirect, input, 1 bit: taken branch or jump from execute.
REQ-006 SHALL have port redirect_addr, input, 8 bits: target instruction address.
REQ-007 SHALL have port instr_in, input, 16 bits: instruction word returned by the instruction memory for pc_out in the same cycle (combinational read).
REQ-008 SHALL have port pc_out, output, 8 bits: current PC; drives the instruction memory address.
REQ-009 SHALL have port ir, output, 16 bits: registered instruction presented to decode.
REQ-010 SHALL have port ir_pc, output, 8 bits: address from which ir was fetched.
REQ-011 SHALL have port ir_valid, output, 1 bit: ir holds a live instruction.
REQ-012 SHALL have port halted, output, 1 bit: fetch is in the HALT state.

Function
REQ-013 SHALL implement a two-state FSM, RUN and HALT, with pc_out driven directly from the PC register.
REQ-014 In RUN with redirect=0 and stall=0, on each edge: ir<=instr_in, ir_pc<=PC, ir_valid<=1, PC<=PC+1.
REQ-015 SHALL compute the PC increment modulo 256, so 8'hFF wraps to 8'h00 with no flag or error.
REQ-016 With stall=1 and redirect=0, SHALL hold PC, ir, ir_pc, ir_valid and state unchanged.
REQ-017 With redirect=1, in any state and regardless of stall, SHALL set PC<=redirect_addr, ir_valid<=0 and state<=RUN; ir and ir_pc may hold any value.
REQ-018 SHALL insert exactly one bubble after a redirect: the target instruction appears in ir with ir_valid=1 on the second edge after redirect is sampled, provided stall=0.
REQ-019 In HALT with redirect=0: PC holds; if stall=0, ir_valid<=0; if stall=1, ir_valid holds.
REQ-020 halted SHALL equal 1 exactly when the state is HALT.
REQ-021 pc_out SHALL never change except through REQ-014, REQ-017 or reset.

Reset
REQ-022 On rst=1, asynchronously and independent of clk, SHALL set PC=RESET_PC, ir=16'h0000, ir_pc=8'h00, ir_valid=0 and state=RUN, so halted=0.
REQ-023 Reset asserted mid-operation, including in HALT or during stall, SHALL abandon all in-flight state.
REQ-024 On the first edge after rst deasserts, SHALL fetch from RESET_PC.

Configuration
REQ-025 With macro IFETCH_HALT_DETECT_EN defined, a fetch under REQ-014 with instr_in[15:12]=4'b1111 SHALL still load ir with ir_valid=1, but SHALL leave PC unchanged and set state<=HALT.
REQ-026 With IFETCH_HALT_DETECT_EN undefined, opcode 4'b1111 SHALL be fetched like any other instruction, HALT SHALL be unreachable, and halted SHALL be tied to 0.

Verification
REQ-027 Sequential fetch: reset, RESET_PC=0, memory holds 16'h4100, 16'h4202, 16'h0321 at 0..2, stall=0 -> after edges 1/2/3, ir=4100/4202/0321, ir_pc=0/1/2, ir_valid=1, pc_out=1/2/3.
REQ-028 Stall: assert stall for 3 cycles at pc_out=2 -> ir, ir_pc and pc_out frozen for 3 edges; on release, fetch resumes at address 2 with no instruction skipped or repeated.
REQ-029 Redirect over stall: redirect=1, redirect_addr=8'h40, stall=1 for one cycle -> next edge ir_valid=0 and pc_out=8'h40; following edge ir=mem[0x40], ir_pc=8'h40.
REQ-030 Wrap: PC=8'hFF, stall=0 -> ir_pc=8'hFF and pc_out=8'h00 after one edge.
REQ-031 Halt, macro defined: 16'hF000 at address 5 -> ir=F000, ir_valid=1, halted=1, pc_out stays 5; next edge ir_valid=0; redirect to 8'h00 -> halted=0, fetch restarts at 0. With the macro undefined, F000 is fetched and pc_out=6.
REQ-032 Async reset: assert rst between clock edges while in HALT with ir_valid=1 -> outputs take their reset values immediately, before the next edge.
